// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions.
//   fp_state_t    : sequencing states of the multi-cycle FP blocks
//   QNAN, EXP_MAX : canonical quiet NaN and all-ones exponent field
//   fp_unpacked_t : sign, exponent[7:0], mantissa[24:0] (hidden bit, fraction, guard)
//   fp_pack       : repack a working mantissa into an IEEE754 word, dropping the guard bit
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ALIGN = 3'd2,
    ARITH = 3'd3,
    NORM  = 3'd4,
    DONE  = 3'd5
  } fp_state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [24:0] mantissa;
  } fp_unpacked_t;

  // A clear hidden bit can only remain when the exponent has bottomed out
  // at 1, which encodes as a denormal with exponent field 0. Rounding is
  // truncation, so the guard bit is simply dropped.
  function automatic logic [31:0] fp_pack(input logic        sign,
                                          input logic [7:0]  exponent,
                                          input logic [24:0] mantissa);
    logic [7:0] exp_field;
    if (mantissa[24]) begin
      exp_field = exponent;
    end else begin
      exp_field = 8'd0;
    end
    return {sign, exp_field, mantissa[23:1]};
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE754 single-precision unpacker.
//   word     : 32-bit packed float
//   unpacked : sign, effective exponent (field 0 treated as 1), 25-bit mantissa
//              {hidden, fraction, guard=0}
//   is_nan / is_inf / is_zero : class flags of the word
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]  word,
  output fp_unpacked_t unpacked,
  output logic         is_nan,
  output logic         is_inf,
  output logic         is_zero
);

  logic [7:0]  exp_field_s;
  logic [22:0] frac_s;

  assign exp_field_s = word[30:23];
  assign frac_s      = word[22:0];

  // Field decode and classification.
  always_comb begin
    unpacked.sign = word[31];
    if (exp_field_s == 8'd0) begin
      // Denormals share the exponent of the smallest normal, without hidden bit.
      unpacked.exponent = 8'd1;
      unpacked.mantissa = {1'b0, frac_s, 1'b0};
    end else begin
      unpacked.exponent = exp_field_s;
      unpacked.mantissa = {1'b1, frac_s, 1'b0};
    end
    is_nan  = (exp_field_s == EXP_MAX) && (frac_s != 23'd0);
    is_inf  = (exp_field_s == EXP_MAX) && (frac_s == 23'd0);
    is_zero = (exp_field_s == 8'd0)    && (frac_s == 23'd0);
  end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Sequential IEEE754 single-precision subtractor: result = dataa - datab.
// Truncating rounding, bit-serial alignment and normalisation.
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only while idle)
//   dataa, datab        : minuend, subtrahend
//   out_valid/out_ready : result handshake (valid only while done)
//   result              : difference, held stable until accepted
module fp_subtractor_seq
  import fp_pkg::*;
#(
  parameter int unsigned ALIGN_LIMIT = 26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam logic [8:0] ALIGN_LIMIT_W = 9'(ALIGN_LIMIT);

  fp_state_t    state_r, state_next_s;

  // b_r holds the subtrahend with its sign already inverted, so the rest of
  // the datapath is a plain signed-magnitude adder.
  logic [31:0]  a_r, b_r, result_r;
  logic         sign_a_r, sign_b_r, res_sign_r;
  logic [7:0]   exp_a_r, exp_b_r, res_exp_r;
  logic [24:0]  man_a_r, man_b_r, res_man_r;

  fp_unpacked_t a_unp_s, b_unp_s;
  logic         a_nan_s, a_inf_s, a_zero_s;
  logic         b_nan_s, b_inf_s, b_zero_s;

  logic         check_hit_s;
  logic [31:0]  check_result_s;
  logic         a_ge_b_s, flush_s;
  logic [7:0]   exp_diff_s;
  logic [25:0]  sum_s;
  logic         ar_sign_s, ar_zero_s, ar_inf_s, ar_done_s;
  logic [7:0]   ar_exp_s;
  logic [24:0]  ar_man_s;
  logic [31:0]  ar_result_s;
  logic [24:0]  nm_man_s;
  logic [7:0]   nm_exp_s;
  logic         nm_done_s;
  logic [31:0]  nm_result_s;

  fp_unpack u_unpack_a (
    .word     (a_r),
    .unpacked (a_unp_s),
    .is_nan   (a_nan_s),
    .is_inf   (a_inf_s),
    .is_zero  (a_zero_s)
  );

  fp_unpack u_unpack_b (
    .word     (b_r),
    .unpacked (b_unp_s),
    .is_nan   (b_nan_s),
    .is_inf   (b_inf_s),
    .is_zero  (b_zero_s)
  );

  // Special-operand resolution; b_r carries the inverted subtrahend sign.
  always_comb begin
    check_hit_s    = 1'b1;
    check_result_s = 32'd0;
    if (a_nan_s) begin
      check_result_s = a_r;
    end else if (b_nan_s) begin
      // Restore the caller's original subtrahend word.
      check_result_s = {~b_r[31], b_r[30:0]};
    end else if (a_inf_s && b_inf_s && (a_r[31] != b_r[31])) begin
      // Same-signed infinities in the original operands cancel.
      check_result_s = QNAN;
    end else if (a_inf_s) begin
      check_result_s = a_r;
    end else if (b_inf_s) begin
      check_result_s = b_r;
    end else if (b_zero_s) begin
      check_result_s = a_r;
    end else if (a_zero_s) begin
      check_result_s = b_r;
    end else begin
      check_hit_s = 1'b0;
    end
  end

  // Exponent distance between the working operands and the flush decision.
  always_comb begin
    a_ge_b_s = (exp_a_r >= exp_b_r);
    if (a_ge_b_s) begin
      exp_diff_s = exp_a_r - exp_b_r;
    end else begin
      exp_diff_s = exp_b_r - exp_a_r;
    end
    flush_s = ({1'b0, exp_diff_s} >= ALIGN_LIMIT_W);
  end

  // Aligned signed-magnitude add; exponents are equal by the time this is used.
  always_comb begin
    sum_s     = {1'b0, man_a_r} + {1'b0, man_b_r};
    ar_sign_s = 1'b0;
    ar_exp_s  = exp_a_r;
    ar_man_s  = 25'd0;
    ar_zero_s = 1'b0;
    if (sign_a_r == sign_b_r) begin
      ar_sign_s = sign_a_r;
      if (sum_s[25]) begin
        ar_man_s = sum_s[25:1];
        ar_exp_s = exp_a_r + 8'd1;
      end else begin
        ar_man_s = sum_s[24:0];
      end
    end else if (man_a_r == man_b_r) begin
      ar_zero_s = 1'b1;
    end else if (man_a_r > man_b_r) begin
      ar_sign_s = sign_a_r;
      ar_man_s  = man_a_r - man_b_r;
    end else begin
      ar_sign_s = sign_b_r;
      ar_man_s  = man_b_r - man_a_r;
    end
    ar_inf_s  = (ar_exp_s == EXP_MAX);
    // Already normalised (or pinned at the denormal exponent): skip NORM.
    ar_done_s = ar_zero_s || ar_inf_s || ar_man_s[24] || (ar_exp_s == 8'd1);
    if (ar_zero_s) begin
      ar_result_s = 32'd0;
    end else if (ar_inf_s) begin
      ar_result_s = {ar_sign_s, EXP_MAX, 23'd0};
    end else begin
      ar_result_s = fp_pack(ar_sign_s, ar_exp_s, ar_man_s);
    end
  end

  // One normalisation step; packing happens in the step that finishes.
  always_comb begin
    nm_man_s    = res_man_r << 1;
    nm_exp_s    = res_exp_r - 8'd1;
    nm_done_s   = nm_man_s[24] || (nm_exp_s == 8'd1);
    nm_result_s = fp_pack(res_sign_r, nm_exp_s, nm_man_s);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = IDLE;
        end
      end
      CHECK: begin
        if (check_hit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = ALIGN;
        end
      end
      ALIGN: begin
        // A distance of 1 finishes with the shift made this cycle.
        if (flush_s || (exp_diff_s <= 8'd1)) begin
          state_next_s = ARITH;
        end else begin
          state_next_s = ALIGN;
        end
      end
      ARITH: begin
        if (ar_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = NORM;
        end
      end
      NORM: begin
        if (nm_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = NORM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = (state_r == IDLE);
    out_valid = (state_r == DONE);
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_r        <= 32'd0;
      b_r        <= 32'd0;
      result_r   <= 32'd0;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      res_sign_r <= 1'b0;
      exp_a_r    <= 8'd0;
      exp_b_r    <= 8'd0;
      res_exp_r  <= 8'd0;
      man_a_r    <= 25'd0;
      man_b_r    <= 25'd0;
      res_man_r  <= 25'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r <= dataa;
            b_r <= {~datab[31], datab[30:0]};
          end
        end
        CHECK: begin
          if (check_hit_s) begin
            result_r <= check_result_s;
          end else begin
            sign_a_r <= a_unp_s.sign;
            exp_a_r  <= a_unp_s.exponent;
            man_a_r  <= a_unp_s.mantissa;
            sign_b_r <= b_unp_s.sign;
            exp_b_r  <= b_unp_s.exponent;
            man_b_r  <= b_unp_s.mantissa;
          end
        end
        ALIGN: begin
          if (flush_s) begin
            if (a_ge_b_s) begin
              man_b_r <= 25'd0;
              exp_b_r <= exp_a_r;
            end else begin
              man_a_r <= 25'd0;
              exp_a_r <= exp_b_r;
            end
          end else if (exp_diff_s != 8'd0) begin
            if (a_ge_b_s) begin
              man_b_r <= man_b_r >> 1;
              exp_b_r <= exp_b_r + 8'd1;
            end else begin
              man_a_r <= man_a_r >> 1;
              exp_a_r <= exp_a_r + 8'd1;
            end
          end
        end
        ARITH: begin
          res_sign_r <= ar_sign_s;
          res_exp_r  <= ar_exp_s;
          res_man_r  <= ar_man_s;
          if (ar_done_s) begin
            result_r <= ar_result_s;
          end
        end
        NORM: begin
          res_exp_r <= nm_exp_s;
          res_man_r <= nm_man_s;
          if (nm_done_s) begin
            result_r <= nm_result_s;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

  assign result = result_r;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Self-checking bench for fp_subtractor_seq: directed cases, back-pressure,
// reset mid-operation, and randomized operands against a reference model.
module tb_fp_subtractor_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  fp_subtractor_seq #(.ALIGN_LIMIT(26)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataa     (dataa),
    .datab     (datab),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: exact integer arithmetic on 25-bit (guard-extended) mantissas,
  // one-shot alignment shift, truncation on pack.
  function automatic logic [31:0] model_sub(input logic [31:0] a, input logic [31:0] bo);
    logic [31:0] b;
    longint ma, mb, sum, mag;
    int ea, eb, e, d;
    logic s;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    b      = bo ^ 32'h8000_0000;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (a_nan) return a;
    if (b_nan) return bo;
    if (a_inf && b_inf && (a[31] == bo[31])) return 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    if (b_zero) return a;
    if (a_zero) return b;
    ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    ma = longint'({a[30:23] != 8'd0, a[22:0]}) * 2;
    mb = longint'({b[30:23] != 8'd0, b[22:0]}) * 2;
    if (ea >= eb) begin
      e = ea; d = ea - eb;
      mb = (d >= 26) ? 0 : (mb >> d);
    end else begin
      e = eb; d = eb - ea;
      ma = (d >= 26) ? 0 : (ma >> d);
    end
    sum = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
    if (sum == 0) return 32'd0;
    s   = (sum < 0);
    mag = s ? -sum : sum;
    if (mag >= (64'd1 << 25)) begin
      mag = mag >> 1;
      e   = e + 1;
      if (e == 255) return {s, 8'hFF, 23'd0};
    end
    while ((mag < (64'd1 << 24)) && (e > 1)) begin
      mag = mag << 1;
      e   = e - 1;
    end
    return {s, (mag >= (64'd1 << 24)) ? 8'(e) : 8'd0, 23'(mag >> 1)};
  endfunction

  function automatic logic [31:0] rand_fp(input int base_exp);
    int k, e;
    k = int'($urandom_range(0, 19));
    case (k)
      0: return {1'($urandom), 31'd0};
      1: return {1'($urandom), 8'hFF, 23'd0};
      2: return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      3: return {1'($urandom), 8'd0, 23'($urandom_range(1, 32'h7F_FFFF))};
      default: begin
        e = base_exp + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), 8'(e), 23'($urandom)};
      end
    endcase
  endfunction

  // Starts and ends on a falling edge. lat counts rising edges from the
  // accepting edge up to the one that raises out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    dataa    = a;
    datab    = b;
    @(negedge clk);
    in_valid = 1'b0;
    dataa    = $urandom;
    datab    = $urandom;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic finish_op(input string tag);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_valid_dropped"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;   // 0: latency not checked
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] res, a, b, expv;
    int lat, saw;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dataa     = 32'd0;
    datab     = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("reset_in_ready", 32'(in_ready), 32'd1);
    check_eq("reset_out_valid", 32'(out_valid), 32'd0);
    check_eq("reset_result", result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    vecs.push_back('{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 0});
    vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 0});
    vecs.push_back('{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 0});
    vecs.push_back('{32'h3F80_0000, 32'h3F7F_FFFF, 32'h3380_0000, 28});
    vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 2});
    vecs.push_back('{32'h3F80_0000, 32'h3080_0000, 32'h3F80_0000, 0});
    vecs.push_back('{32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 0});
    vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0001, 2});
    vecs.push_back('{32'h3F80_0000, 32'hFF80_0001, 32'hFF80_0001, 2});
    vecs.push_back('{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 2});
    vecs.push_back('{32'hFF80_0000, 32'h7F80_0000, 32'hFF80_0000, 2});
    vecs.push_back('{32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 0});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, res, lat);
      check_eq($sformatf("dir%0d_result", i), res, vecs[i].exp);
      if (vecs[i].lat != 0) begin
        check_eq($sformatf("dir%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end
      finish_op($sformatf("dir%0d", i));
    end

    // Back-pressure: result held while out_ready stays low; inputs ignored.
    run_op(32'h4040_0000, 32'h3F80_0000, res, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dataa    = $urandom;
      datab    = $urandom;
      @(negedge clk);
      check_eq($sformatf("bp%0d_result", i), result, 32'h4000_0000);
      check_eq($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      check_eq($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("bp_release_valid", 32'(out_valid), 32'd0);
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Reset while normalising: back to idle, no result ever produced.
    in_valid = 1'b1;
    dataa    = 32'h3F80_0000;
    datab    = 32'h3F7F_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("rst_norm_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_norm_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_norm_result", result, 32'd0);
    reset_n = 1'b1;
    saw = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check_eq("rst_norm_no_output", 32'(saw), 32'd0);

    // Randomized operands against the model.
    for (int i = 0; i < 300; i++) begin
      int base;
      base = int'($urandom_range(1, 254));
      a    = rand_fp(base);
      if ($urandom_range(0, 3) == 0) begin
        b = a ^ 32'($urandom_range(0, 255));
      end else begin
        b = rand_fp(base);
      end
      expv = model_sub(a, b);
      run_op(a, b, res, lat);
      if (res !== expv) begin
        $display("  operands a=%08h b=%08h", a, b);
      end
      check_eq($sformatf("rnd%0d_result", i), res, expv);
      check_eq($sformatf("rnd%0d_lat_le_52", i), 32'(lat <= 52), 32'd1);
      finish_op($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_subtractor_seq.md
FP_SUBTRACTOR_SEQ -- requirements
Module: fp_subtractor_seq

Interface
REQ-001 SHALL have parameter ALIGN_LIMIT, default 26: exponent difference at or above which the smaller operand is flushed to zero in one cycle.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: dataa/datab valid.
REQ-005 SHALL have port in_ready, output, 1 bit: high only in IDLE.
REQ-006 SHALL have port dataa, input, 32 bits: IEEE754 single-precision minuend.
REQ-007 SHALL have port datab, input, 32 bits: IEEE754 single-precision subtrahend.
REQ-008 SHALL have port out_valid, output, 1 bit: result valid, high only in DONE.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-010 SHALL have port result, output, 32 bits: dataa - datab, IEEE754 single precision.

Function
REQ-011 SHALL compute dataa - datab by inverting datab[31] at capture, then performing signed-magnitude addition.
REQ-012 SHALL capture operands on the cycle where in_valid and in_ready are both high, and move IDLE->CHECK.
REQ-013 CHECK SHALL resolve special cases in 1 cycle, then go to DONE; otherwise it SHALL go to ALIGN.
- NaN operand -> that operand unchanged, dataa first.
- inf - inf of the same sign -> 0x7FC00000.
- Any other inf -> signed inf.
- B zero -> A.
- A zero -> negated B.
REQ-014 Unpack SHALL treat exponent 0 as exponent 1 with hidden bit 0, else hidden bit 1; mantissas SHALL carry 1 extra guard LSB (25 bits).
REQ-015 ALIGN SHALL shift the smaller-exponent mantissa right 1 bit per cycle, incrementing its exponent, until the exponents are equal.
REQ-016 If the exponent difference is >= ALIGN_LIMIT, ALIGN SHALL zero that mantissa in 1 cycle.
REQ-017 ARITH SHALL take 1 cycle.
- Equal signs: add the magnitudes.
- Unequal signs: subtract the smaller magnitude from the larger; sign follows the larger.
- Equal magnitudes: +0.
- Carry out: shift right 1 and increment the exponent.
REQ-018 NORM SHALL shift left 1 bit per cycle, decrementing the exponent, until the hidden bit is set or the exponent equals 1.
- If the exponent equals 1 with the hidden bit clear, the result SHALL be packed with exponent field 0 (denormal).
REQ-019 Rounding SHALL be truncation; the guard bit SHALL be discarded at pack.
REQ-020 An exponent reaching 255 after carry SHALL produce signed inf (mantissa 0).
REQ-021 Worst-case latency from accept to out_valid SHALL be 1+1+25+1+24 = 52 cycles; CHECK-resolved cases SHALL take exactly 2 cycles.
REQ-022 result and out_valid SHALL hold stable in DONE until out_ready is high.
- On handshake: DONE->IDLE, out_valid low next cycle.
- No new input SHALL be accepted in the same cycle (in_ready low).
REQ-023 Inputs SHALL be ignored outside IDLE; dataa/datab changes mid-operation SHALL NOT affect the result.

Reset
REQ-024 When reset_n is low at a clock edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, result=0, and all internal registers cleared, from any state including mid-ALIGN/NORM.
REQ-025 A transaction interrupted by reset SHALL produce no output.

Structure
REQ-026 State enum (IDLE, CHECK, ALIGN, ARITH, NORM, DONE), QNAN=0x7FC00000, EXP_MAX=8'hFF, and the unpacked-float struct (sign, exponent[7:0], mantissa[24:0]) SHALL reside in shared package fp_pkg, reused by the other FP blocks.
REQ-027 SHALL instantiate one sub-module, fp_unpack, which is combinational: 32-bit word -> unpacked struct plus is_nan/is_inf/is_zero flags, instantiated twice.

Verification
REQ-028 0x40400000 - 0x3F800000 -> result 0x40000000.
REQ-029 0x3F800000 - 0x3F800000 -> result 0x00000000.
REQ-030 0x3F800000 - 0xBF800000 -> result 0x40000000 via the carry path.
REQ-031 0x3F800000 - 0x3F7FFFFF -> result 0x33800000 after 24 NORM cycles.
REQ-032 Special cases:
- 0x7F800000 - 0x7F800000 -> 0x7FC00000 in 2 cycles.
- 0x3F800000 - 0x30800000 -> 0x3F800000 via the ALIGN_LIMIT flush.
REQ-033 Back-pressure and reset:
- out_ready held low 10 cycles -> result and out_valid stable.
- reset_n low during NORM -> IDLE next cycle, out_valid never asserts.
